// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction field layout, control opcodes and sequencer states.
// Imported by the program sequencer, its return stack and its bus interface.
package proc_pkg;

    localparam int ADDR_W  = 13;
    localparam int INSTR_W = 18;
    localparam int OPC_W   = 5;
    localparam int REG_W   = 4;
    localparam int OFF_W   = 9;

    localparam int OPC_HI  = 17;
    localparam int OPC_LO  = 13;
    localparam int OFF_HI  = 12;
    localparam int OFF_LO  = 4;
    localparam int REG_HI  = 3;
    localparam int REG_LO  = 0;
    localparam int TGT_HI  = 12;
    localparam int TGT_LO  = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_BRZ = 5'b11000,
        OP_JMP = 5'b11010,
        OP_RET = 5'b11100
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } seq_state_e;

    // Branch offsets are relative to the address of the BRZ itself.
    function automatic logic [ADDR_W-1:0] brz_target(input logic [ADDR_W-1:0] pc,
                                                     input logic [OFF_W-1:0]  off);
        return pc + {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
    endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Bus bundle between the program sequencer, program ROM, register file zero test and datapath.
// master = sequencer side, slave = environment side.
interface pc_seq_if;
    import proc_pkg::*;

    logic               start;
    logic               ready;
    logic [ADDR_W-1:0]  padr;
    logic [INSTR_W-1:0] dout;
    logic [REG_W-1:0]   rz_sel;
    logic               rz_zero;
    logic               exec_valid;
    logic [INSTR_W-1:0] exec_instr;
    logic               stall;
    logic               rstk_err;

    modport master (
        input  start, dout, rz_zero, stall,
        output ready, padr, rz_sel, exec_valid, exec_instr, rstk_err
    );

    modport slave (
        output start, dout, rz_zero, stall,
        input  ready, padr, rz_sel, exec_valid, exec_instr, rstk_err
    );

endinterface

// File: rtl/pc_seq_rstk.sv
// Circular return-address LIFO: push on a full stack overwrites the oldest entry, the level saturates.
// The full flag is exported only when PC_SEQ_RSTK_CHECK_EN is defined.
module pc_seq_rstk
    import proc_pkg::*;
#(
    parameter int RSTK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty
`ifdef PC_SEQ_RSTK_CHECK_EN
   ,output logic              full
`endif
);

    localparam int PTR_W = $clog2(RSTK_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]     mem_reg [RSTK_DEPTH];
    logic [PTR_W-1:0]      head_reg;
    logic [CNT_W-1:0]      sp_reg;
    logic [RSTK_DEPTH-1:0] wr_en;
    logic                  full_int;

    assign full_int = (sp_reg == CNT_W'(RSTK_DEPTH));
    assign empty    = (sp_reg == '0);
    // head is the next free slot, so the newest entry sits one below it
    assign top      = mem_reg[head_reg - PTR_W'(1)];

`ifdef PC_SEQ_RSTK_CHECK_EN
    assign full = full_int;
`endif

    generate
        for (genvar gi = 0; gi < RSTK_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = push && !clear && (head_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int i = 0; i < RSTK_DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_reg[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            head_reg <= '0;
            sp_reg   <= '0;
        end else if (push) begin
            head_reg <= head_reg + PTR_W'(1);
            if (!full_int) begin
                sp_reg <= sp_reg + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            head_reg <= head_reg - PTR_W'(1);
            sp_reg   <= sp_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_seq.sv
// Program sequencer: owns the PC, runs BRZ/JMP/RET itself and hands every other opcode to the datapath.
// Define PC_SEQ_RSTK_CHECK_EN to build the sticky return-stack over/underflow flag (rstk_err).
module pc_seq
    import proc_pkg::*;
#(
    parameter int RSTK_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_seq_if.master  bus
);

    seq_state_e         state_reg;
    logic [ADDR_W-1:0]  pc_reg;
    logic               ready_reg;

    logic [OPC_W-1:0]   opc;
    logic               is_brz;
    logic               is_jmp;
    logic               is_ret;
    logic               is_ctrl;
    logic               run;
    logic               advance;

    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  pc_next;
    logic [ADDR_W-1:0]  jmp_tgt;
    logic               go_idle;

    logic               rstk_push;
    logic               rstk_pop;
    logic               rstk_clear;
    logic [ADDR_W-1:0]  rstk_top;
    logic               rstk_empty;

    assign opc     = bus.dout[OPC_HI:OPC_LO];
    assign is_brz  = (opc == OP_BRZ);
    assign is_jmp  = (opc == OP_JMP);
    assign is_ret  = (opc == OP_RET);
    assign is_ctrl = is_brz || is_jmp || is_ret;

    assign run     = (state_reg == ST_RUN);
    assign advance = run && !bus.stall;

    assign pc_inc  = pc_reg + ADDR_W'(1);
    assign jmp_tgt = bus.dout[TGT_HI:TGT_LO];

    always_comb begin
        pc_next   = pc_inc;
        rstk_push = 1'b0;
        rstk_pop  = 1'b0;
        if (is_brz) begin
            pc_next = bus.rz_zero ? brz_target(pc_reg, bus.dout[OFF_HI:OFF_LO]) : pc_inc;
        end else if (is_jmp) begin
            pc_next   = jmp_tgt;
            rstk_push = advance && (jmp_tgt != '0);
        end else if (is_ret) begin
            pc_next  = rstk_empty ? '0 : rstk_top;
            rstk_pop = advance && !rstk_empty;
        end
    end

    // Address 0 is the idle loop: any flow that lands there ends the program.
    assign go_idle    = (pc_next == '0);
    assign rstk_clear = advance && go_idle;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            ready_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_reg <= ST_RUN;
                        pc_reg    <= ADDR_W'(1);
                        ready_reg <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (go_idle) begin
                            state_reg <= ST_IDLE;
                            pc_reg    <= '0;
                            ready_reg <= 1'b1;
                        end else begin
                            pc_reg <= pc_next;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    pc_reg    <= '0;
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

`ifdef PC_SEQ_RSTK_CHECK_EN
    logic rstk_full;
    logic err_reg;
`endif

    pc_seq_rstk #(
        .RSTK_DEPTH (RSTK_DEPTH)
    ) u_rstk (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (rstk_clear),
        .push      (rstk_push),
        .pop       (rstk_pop),
        .push_data (pc_inc),
        .top       (rstk_top),
        .empty     (rstk_empty)
`ifdef PC_SEQ_RSTK_CHECK_EN
       ,.full      (rstk_full)
`endif
    );

`ifdef PC_SEQ_RSTK_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if ((rstk_push && rstk_full) || (advance && is_ret && rstk_empty)) begin
            err_reg <= 1'b1;
        end
    end
    assign bus.rstk_err = err_reg;
`else
    assign bus.rstk_err = 1'b0;
`endif

    assign bus.padr       = pc_reg;
    assign bus.ready      = ready_reg;
    assign bus.rz_sel     = bus.dout[REG_HI:REG_LO];
    assign bus.exec_valid = run && !is_ctrl;
    assign bus.exec_instr = bus.dout;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: a table of per-cycle vectors walks one program through
// sequential ops, stall, BRZ, JMP/RET nesting, stack overflow and JMP 0; hand sequences cover reset and underflow.
module tb_pc_seq;
    import proc_pkg::*;

`ifdef PC_SEQ_RSTK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    typedef struct {
        logic        start;
        logic        stall;
        logic        rz;
        logic [12:0] padr;
        logic        ev;
        logic        rdy;
        logic        err;   // error expected when checking is built in
    } vec_t;

    logic clk;
    logic rst_n;
    logic [17:0] rom [0:8191];
    vec_t vecs[$];
    int   n_cmp;
    int   n_err;

    pc_seq_if bif();

    pc_seq #(.RSTK_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.master)
    );

    assign bif.dout = rom[bif.padr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] f_addi(input logic [12:0] a);
        return {5'b00100, a};
    endfunction
    function automatic logic [17:0] f_jmp(input logic [12:0] t);
        return {5'b11010, t};
    endfunction
    function automatic logic [17:0] f_brz(input logic [8:0] off, input logic [3:0] r);
        return {5'b11000, off, r};
    endfunction
    function automatic logic [17:0] f_ret();
        return {5'b11100, 13'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic sl, input logic rz, input int pa,
                       input logic ev, input logic rdy, input logic err);
        vec_t v;
        v.start = st; v.stall = sl; v.rz = rz; v.padr = 13'(pa);
        v.ev = ev; v.rdy = rdy; v.err = err;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        for (int i = 0; i < 8192; i++) rom[i] = f_jmp(13'd0);
        for (int i = 0; i <= 13; i++) rom[i] = f_addi(13'(i));
        rom[14]  = f_jmp(13'd200);
        rom[15]  = f_addi(13'd15);
        rom[16]  = f_jmp(13'd200);
        rom[17]  = f_jmp(13'd300);
        rom[200] = f_brz(9'd6, 4'd6);
        for (int i = 201; i <= 204; i++) rom[i] = f_addi(13'(i));
        rom[205] = f_brz(9'h1FD, 4'd0);
        rom[206] = f_addi(13'd206);
        rom[207] = f_ret();
        rom[300] = f_jmp(13'd310);
        rom[310] = f_jmp(13'd320);
        rom[320] = f_jmp(13'd330);
        rom[330] = f_jmp(13'd340);
        rom[340] = f_ret();
        rom[331] = f_ret();
        rom[321] = f_ret();
        rom[311] = f_ret();
        rom[301] = f_jmp(13'd46);

        // start, ADDI run, stall on 5, ignored start at 7
        add(1, 0, 0, 0, 0, 1, 0);
        for (int a = 1; a <= 4; a++) add(0, 0, 0, a, 1, 0, 0);
        repeat (3) add(0, 1, 0, 5, 1, 0, 0);
        add(0, 0, 0, 5, 1, 0, 0);
        for (int a = 6; a <= 13; a++) add(logic'(a == 7), 0, 0, a, 1, 0, 0);
        // JMP 200, BRZ not taken, BRZ R0,-3 taken, then not taken, RET -> 15
        add(0, 0, 0, 14, 0, 0, 0);
        add(0, 0, 0, 200, 0, 0, 0);
        for (int a = 201; a <= 204; a++) add(0, 0, 0, a, 1, 0, 0);
        add(0, 0, 1, 205, 0, 0, 0);
        for (int a = 202; a <= 204; a++) add(0, 0, 0, a, 1, 0, 0);
        add(0, 0, 0, 205, 0, 0, 0);
        add(0, 0, 0, 206, 1, 0, 0);
        add(0, 0, 0, 207, 0, 0, 0);
        add(0, 0, 0, 15, 1, 0, 0);
        // second call: BRZ stalled with rz=0, then taken with rz=1 -> 206, RET -> 17
        add(0, 0, 0, 16, 0, 0, 0);
        add(0, 1, 0, 200, 0, 0, 0);
        add(0, 0, 1, 200, 0, 0, 0);
        add(0, 0, 0, 206, 1, 0, 0);
        add(0, 0, 0, 207, 0, 0, 0);
        // five nested JMPs overflow the 4-deep stack, four RETs, JMP 46, default JMP 0
        add(0, 0, 0, 17, 0, 0, 0);
        add(0, 0, 0, 300, 0, 0, 0);
        add(0, 0, 0, 310, 0, 0, 0);
        add(0, 0, 0, 320, 0, 0, 0);
        add(0, 0, 0, 330, 0, 0, 0);
        add(0, 0, 0, 340, 0, 0, 1);
        add(0, 0, 0, 331, 0, 0, 1);
        add(0, 0, 0, 321, 0, 0, 1);
        add(0, 0, 0, 311, 0, 0, 1);
        add(0, 0, 0, 301, 0, 0, 1);
        add(0, 0, 0, 46, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1, 1);

        bif.start = 1'b0; bif.stall = 1'b0; bif.rz_zero = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bif.ready), 32'd1);
        check("rst_padr", 32'(bif.padr), 32'd0);
        check("rst_err", 32'(bif.rstk_err), 32'd0);
        rst_n = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check($sformatf("idle%0d_ready", c), 32'(bif.ready), 32'd1);
            check($sformatf("idle%0d_padr", c), 32'(bif.padr), 32'd0);
            check($sformatf("idle%0d_ev", c), 32'(bif.exec_valid), 32'd0);
            $display("idle cycle %0d: padr=%0d ready=%0b ev=%0b", c, bif.padr, bif.ready, bif.exec_valid);
        end

        foreach (vecs[i]) begin
            @(negedge clk);
            bif.start   = vecs[i].start;
            bif.stall   = vecs[i].stall;
            bif.rz_zero = vecs[i].rz;
            #1;
            check($sformatf("v%0d_padr", i), 32'(bif.padr), 32'(vecs[i].padr));
            check($sformatf("v%0d_ev", i), 32'(bif.exec_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_ready", i), 32'(bif.ready), 32'(vecs[i].rdy));
            check($sformatf("v%0d_err", i), 32'(bif.rstk_err), 32'(vecs[i].err & CHK));
            check($sformatf("v%0d_rzsel", i), 32'(bif.rz_sel), 32'(rom[vecs[i].padr][3:0]));
            if (vecs[i].ev)
                check($sformatf("v%0d_instr", i), 32'(bif.exec_instr), 32'(rom[vecs[i].padr]));
            $display("vec %0d: start=%0b stall=%0b rz=%0b padr=%0d ev=%0b ready=%0b err=%0b",
                     i, vecs[i].start, vecs[i].stall, vecs[i].rz, bif.padr, bif.exec_valid,
                     bif.ready, bif.rstk_err);
        end

        // restart after JMP 0, then reset in the middle of the run
        @(negedge clk);
        bif.start = 1'b1; bif.stall = 1'b0; bif.rz_zero = 1'b0;
        #1;
        check("rs_idle_ready", 32'(bif.ready), 32'd1);
        @(negedge clk);
        bif.start = 1'b0;
        #1;
        check("rs_padr1", 32'(bif.padr), 32'd1);
        check("rs_ready0", 32'(bif.ready), 32'd0);
        $display("restart: padr=%0d ready=%0b", bif.padr, bif.ready);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rs_padr2", 32'(bif.padr), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mrst_padr", 32'(bif.padr), 32'd0);
        check("mrst_ready", 32'(bif.ready), 32'd1);
        check("mrst_ev", 32'(bif.exec_valid), 32'd0);
        check("mrst_err", 32'(bif.rstk_err), 32'd0);
        $display("mid-run reset: padr=%0d ready=%0b err=%0b", bif.padr, bif.ready, bif.rstk_err);

        // RET on an empty stack returns to idle
        rom[1] = f_ret();
        @(negedge clk);
        bif.start = 1'b1;
        #1;
        @(negedge clk);
        bif.start = 1'b0;
        #1;
        check("uf_padr1", 32'(bif.padr), 32'd1);
        check("uf_ev", 32'(bif.exec_valid), 32'd0);
        check("uf_err_before", 32'(bif.rstk_err), 32'd0);
        @(negedge clk);
        #1;
        check("uf_padr0", 32'(bif.padr), 32'd0);
        check("uf_ready", 32'(bif.ready), 32'd1);
        check("uf_err", 32'(bif.rstk_err), 32'(CHK));
        @(negedge clk);
        #1;
        check("uf_err_sticky", 32'(bif.rstk_err), 32'(CHK));
        $display("underflow: padr=%0d ready=%0b err=%0b", bif.padr, bif.ready, bif.rstk_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
